// File: rtl/x_result_fifo.sv
// x_result_fifo
// Capture buffer for the 33-bit `x` result of the test4 datapath. Results are
// held in a small first-word-fall-through FIFO with a valid/ready handshake so
// a slower consumer can drain them without stalling the producer every cycle.
// Every storage register loads only under an explicit enable, which lets the
// gating flow insert clock gates. Offers made while the buffer is full are
// dropped and recorded in a sticky overflow flag.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   in_data    in   WIDTH  result word offered by the producer
//   in_valid   in   1      in_data is offered this cycle
//   in_ready   out  1      FIFO can accept a word this cycle
//   out_data   out  WIDTH  head-of-FIFO word, zero when empty
//   out_valid  out  1      out_data holds a valid word
//   out_ready  in   1      consumer takes out_data this cycle
//   count      out  AW+1   number of stored entries, 0..DEPTH
//   overflow   out  1      sticky: an offer was dropped because FIFO was full
//   ovf_clr    in   1      synchronous clear of overflow
module x_result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  // Flags come from the registered count only, so none of them depends
  // combinationally on in_valid or out_ready.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A full FIFO refuses words even when a pop happens in the same cycle.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && !in_ready;

  // Pointers wrap naturally at AW bits; occupancy is tracked by count alone.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // A new drop outranks a clear arriving in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only the entry addressed by wr_ptr is enabled.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr_q == AW'(i))) begin
        mem_q[i] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_x_result_fifo.sv
// Directed testbench for x_result_fifo: reset state, single word, fill and
// overflow, full with concurrent pop, wrap-around streaming, reset mid-transfer
// and the overflow set/clear priority.
module tb_x_result_fifo;

  localparam int WIDTH = 33;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;
  logic [AW:0]      count;
  logic             overflow;
  logic             ovfClr;

  int compareCount;
  int mismatchCount;

  x_result_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (inData),
    .in_valid (inValid),
    .in_ready (inReady),
    .out_data (outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovfClr)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the
  // rising edge, well away from the next one.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Push one word with the consumer stalled.
  task automatic pushWord(input logic [WIDTH-1:0] word);
    inData  = word;
    inValid = 1'b1;
    applyStimulus();
    inValid = 1'b0;
  endtask

  // Directed sequence; expected values are written out by hand.
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst      = 1'b0;
    inData   = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    ovfClr   = 1'b0;

    // Reset held for 100 ns, then released and idled.
    #100;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_in_ready", 64'(inReady), 64'd1);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_out_data", 64'(outData), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);

    // Single word: visible one edge after the push, gone after the pop.
    pushWord(33'd3);
    checkOutput("single_valid", 64'(outValid), 64'd1);
    checkOutput("single_data", 64'(outData), 64'd3);
    checkOutput("single_count", 64'(count), 64'd1);
    outReady = 1'b1;
    applyStimulus();
    outReady = 1'b0;
    checkOutput("single_pop_count", 64'(count), 64'd0);
    checkOutput("single_pop_data", 64'(outData), 64'd0);

    // Fill to DEPTH, then offer one more which must be dropped.
    for (int i = 1; i <= 4; i++) pushWord(WIDTH'(i));
    checkOutput("fill_count", 64'(count), 64'd4);
    checkOutput("fill_in_ready", 64'(inReady), 64'd0);
    pushWord(33'd5);
    checkOutput("ovf_set", 64'(overflow), 64'd1);
    checkOutput("ovf_count", 64'(count), 64'd4);
    checkOutput("ovf_head", 64'(outData), 64'd1);

    // Full with concurrent pop: 1 leaves, 9 is not accepted.
    inData   = 33'd9;
    inValid  = 1'b1;
    outReady = 1'b1;
    applyStimulus();
    inValid  = 1'b0;
    checkOutput("fullpop_count", 64'(count), 64'd3);
    checkOutput("fullpop_ovf", 64'(overflow), 64'd1);
    checkOutput("fullpop_head", 64'(outData), 64'd2);

    // Drain the rest in order; neither 5 nor 9 ever appears.
    for (int i = 3; i <= 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("drain_%0d", i), 64'(outData), 64'(i));
    end
    applyStimulus();
    checkOutput("drain_empty_count", 64'(count), 64'd0);
    checkOutput("drain_empty_valid", 64'(outValid), 64'd0);

    // Popping an empty FIFO is ignored.
    applyStimulus();
    checkOutput("empty_pop_count", 64'(count), 64'd0);
    outReady = 1'b0;

    // Clear with no drop pending.
    ovfClr = 1'b1;
    applyStimulus();
    ovfClr = 1'b0;
    checkOutput("ovf_clear", 64'(overflow), 64'd0);

    // Streaming with the consumer always ready: occupancy stays at 1 and
    // bit 32 survives; pointers wrap repeatedly.
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inData  = 33'h1_0000_0000 + WIDTH'(i);
      inValid = 1'b1;
      applyStimulus();
      checkOutput($sformatf("stream_data_%0d", i), 64'(outData),
                  64'h1_0000_0000 + 64'(i));
      checkOutput($sformatf("stream_count_%0d", i), 64'(count), 64'd1);
    end
    inValid = 1'b0;
    applyStimulus();
    checkOutput("stream_end_count", 64'(count), 64'd0);
    outReady = 1'b0;

    // Reset between edges with two entries stored: outputs react at once.
    pushWord(33'h11);
    pushWord(33'h22);
    checkOutput("mid_count", 64'(count), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
    checkOutput("mid_rst_count", 64'(count), 64'd0);
    checkOutput("mid_rst_data", 64'(outData), 64'd0);
    checkOutput("mid_rst_ready", 64'(inReady), 64'd1);
    #1;
    rst = 1'b1;
    applyStimulus();

    // After reset only the new word is present.
    pushWord(33'd7);
    checkOutput("post_rst_data", 64'(outData), 64'd7);
    checkOutput("post_rst_count", 64'(count), 64'd1);
    outReady = 1'b1;
    applyStimulus();
    outReady = 1'b0;
    checkOutput("post_rst_no_stale", 64'(outValid), 64'd0);

    // Drop and clear in the same cycle: the drop wins.
    for (int i = 0; i < 4; i++) pushWord(33'h40 + WIDTH'(i));
    inData  = 33'h55;
    inValid = 1'b1;
    ovfClr  = 1'b1;
    applyStimulus();
    inValid = 1'b0;
    checkOutput("ovf_priority", 64'(overflow), 64'd1);
    applyStimulus();
    ovfClr = 1'b0;
    checkOutput("ovf_clr_after", 64'(overflow), 64'd0);
    checkOutput("ovf_head_kept", 64'(outData), 64'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/x_result_fifo.md
# x_result_fifo

Downstream capture stage for the 33-bit result `x` produced by the `test4` datapath. It buffers results in a small first-word-fall-through FIFO with a valid/ready handshake, so a slower consumer can drain them without stalling the producer every cycle. Every storage register loads only under an explicit enable, which makes the block a clock-gating target for the gating flow. It also keeps a sticky overflow flag for results offered while the buffer is full.

## Interface
- `WIDTH`, default 33: data width; matches `x`.
- `DEPTH`, default 4: number of entries; must be a power of two, ≥2.
- `AW`, default `$clog2(DEPTH)`: pointer width; derived, do not override.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clk`.
- `in_data`  in  WIDTH: result word; connected to `x`.
- `in_valid`  in  1: `in_data` is offered this cycle.
- `in_ready`  out  1: FIFO can accept a word this cycle.
- `out_data`  out  WIDTH: head-of-FIFO word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer takes `out_data` this cycle.
- `count`  out  AW+1: number of stored entries, 0..DEPTH.
- `overflow`  out  1: sticky; an offer was dropped because the FIFO was full.
- `ovf_clr`  in  1: synchronous clear of `overflow`.

## Operation
- **Push**: occurs when `in_valid && in_ready`.
  - `mem[wr_ptr] <= in_data`; `wr_ptr` increments modulo DEPTH.
  - Only the addressed entry is enabled.
- **Pop**: occurs when `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- **Simultaneous push and pop**: `count` is unchanged and both pointers advance.
- **Flags** (all combinational from `count`):
  - `in_ready = (count != DEPTH)`.
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]` when `out_valid`, else all zeros.
- **Full** (`count == DEPTH`):
  - `in_ready = 0`; no bypass even if a pop happens in the same cycle.
  - An offer (`in_valid = 1`) is dropped and sets `overflow` on the next edge.
- **Empty**: `out_ready` is ignored. No pop occurs and `rd_ptr` holds.
- **Overflow flag**:
  - Set has priority over `ovf_clr` in the same cycle.
  - `ovf_clr` with no set event clears it on the next edge.
- **Pointer wrap**: pointers are AW bits and wrap naturally. `count` is tracked separately; full/empty are never derived from pointer equality.
- **Reset** (`rst = 0`, any time, including mid-transfer):
  - `wr_ptr = rd_ptr = 0`, `count = 0`, `overflow = 0`.
  - Hence `in_ready = 1`, `out_valid = 0`, `out_data = 0`.
  - Memory contents are not reset; stored data is discarded.
- **Data path**: no arithmetic on data; words pass through unmodified, in order, at full WIDTH.

## Timing
- Push-to-visible latency is 1 cycle. A word pushed at edge N is visible on `out_data` with `out_valid = 1` right after edge N, if the FIFO was empty.
- Pop takes effect at the edge. The next entry, or zero if the FIFO becomes empty, is presented right after that edge.
- `in_ready`, `out_valid`, `out_data` and `count` change only after clock edges or on reset assertion. None of them depends combinationally on `in_valid` or `out_ready`.
- Throughput is 1 push and 1 pop per cycle sustained when neither full nor empty.
- `overflow` is registered and asserts 1 cycle after the dropped offer.

## Test plan
- **Reset**: hold `rst = 0` for 100 ns, release, idle → `in_ready = 1`, `out_valid = 0`, `count = 0`, `out_data = 0`, `overflow = 0`.
- **Single word**: push 3 (a=2, b=1, s=1 result) with `out_ready = 0` → next cycle `out_valid = 1`, `out_data = 3`, `count = 1`. Then pulse `out_ready` → `count = 0`, `out_data = 0`.
- **Fill and overflow**:
  - Push 1, 2, 3, 4 with `out_ready = 0` → `count = 4`, `in_ready = 0`.
  - Offer 5 → dropped, `overflow = 1`.
  - Drain → outputs 1, 2, 3, 4 in order; 5 never appears.
- **Full with concurrent pop**: at `count = 4`, assert `in_valid` (data 9) and `out_ready` together → pop 1, no push, `count = 3`, `overflow = 1`.
- **Wrap-around streaming**: 10 consecutive pushes 0x1_0000_0000 + i with `out_ready = 1` throughout → `count` stays at most 1; outputs appear in order, bit 32 preserved; pointers wrap twice.
- **Reset mid-operation**:
  - With `count = 2`, pulse `rst = 0` between edges → outputs go to reset values immediately.
  - After release, push 7 → `out_data = 7`; no stale entries.
  - `ovf_clr` and a new overflow in the same cycle → `overflow` stays 1.
